// File: rtl/regex_driver.sv
// regex_driver: feeds a buffered character stream into a compiled regex match
// network, one character per clock and no gaps within a string. It then turns
// the network's delayed match output into position reports.
// Build option: define REGEX_UNANCHORED_EN to drive the start token on every
// character (search mode). When it is undefined, matches are anchored at string start.
module regex_driver #(
  parameter int CHAR_W     = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int POS_W      = 16,
  parameter int MATCH_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [CHAR_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              i,
  output logic [CHAR_W-1:0] i_c,
  input  logic              o,
  output logic              rx_clr,
  output logic              m_valid,
  output logic [POS_W-1:0]  m_pos,
  input  logic              m_ready,
  output logic              err,
  output logic              m_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_CLR, ST_SKIP} state_t;

  // Each FIFO entry stores {last, data}.
  logic [CHAR_W:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d, str_cnt_q, str_cnt_d;
  logic          rdy_q;
  state_t        state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [2:0]    drain_q, drain_d;
  logic          i_q, i_d, rx_clr_q, rx_clr_d, err_q, err_d;
  logic [CHAR_W-1:0] i_c_q, i_c_d;
  logic [MATCH_LAT:0]            dl_valid_q, dl_valid_d;
  logic [MATCH_LAT:0][POS_W-1:0] dl_pos_q, dl_pos_d;
  logic          m_valid_q, m_valid_d, m_drop_q, m_drop_d;
  logic [POS_W-1:0] m_pos_q, m_pos_d;

  logic push, pop, flush, dl0_valid, capture, consume;
  logic fifo_full, fifo_empty, head_last;
  logic [CHAR_W:0]   head;
  logic [CHAR_W-1:0] head_data;

  assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign s_ready    = rdy_q & ~fifo_full;
  assign push       = s_valid & s_ready;
  assign head       = mem[rd_ptr_q];
  assign head_last  = head[CHAR_W];
  assign head_data  = head[CHAR_W-1:0];

  // FIFO storage. The storage has no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {s_last, s_data};
  end

  // Next-state logic for the FIFO pointers, occupancy, and complete-string count.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    str_cnt_d  = str_cnt_q + CW'(push & s_last) - CW'(pop & head_last);
  end

  // Sequencer: streams one string, drains the in-flight results, then clears the network.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    pos_d     = pos_q;
    drain_d   = drain_q;
    i_d       = 1'b0;
    i_c_d     = '0;
    rx_clr_d  = 1'b0;
    err_d     = err_q;
    flush     = 1'b0;
    dl0_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pos_d = '0;
        // A full FIFO with no last marker holds an overlength string. Start it anyway.
        if (str_cnt_q != '0 || fifo_full) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          i_c_d     = head_data;
          dl0_valid = 1'b1;
`ifdef REGEX_UNANCHORED_EN
          i_d       = 1'b1;
`else
          i_d       = (pos_q == '0);
`endif
          if (pos_q != '1) pos_d = pos_q + POS_W'(1);
          if (head_last) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end else begin
          // Underrun: discard this string's results and reset the network.
          err_d    = 1'b1;
          rx_clr_d = 1'b1;
          flush    = 1'b1;
          state_d  = ST_SKIP;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 3'(MATCH_LAT - 1)) state_d = ST_CLR;
        else drain_d = drain_q + 3'd1;
      end
      ST_CLR: begin
        rx_clr_d = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_SKIP: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Delay line that aligns {valid, pos} with the network's match latency.
  always_comb begin
    dl_valid_d    = '0;
    dl_pos_d      = '0;
    dl_valid_d[0] = dl0_valid;
    dl_pos_d[0]   = pos_q;
    for (int k = 1; k <= MATCH_LAT; k++) begin
      dl_valid_d[k] = dl_valid_q[k-1] & ~flush;
      dl_pos_d[k]   = dl_pos_q[k-1];
    end
  end

  // Single-entry report register. A match that arrives while the register is held is dropped and the drop is flagged.
  always_comb begin
    capture   = o & dl_valid_q[MATCH_LAT] & ~flush;
    consume   = m_valid_q & m_ready;
    m_valid_d = m_valid_q & ~consume;
    m_pos_d   = m_pos_q;
    m_drop_d  = m_drop_q;
    if (capture) begin
      if (!m_valid_q || consume) begin
        m_valid_d = 1'b1;
        m_pos_d   = dl_pos_q[MATCH_LAT];
      end else begin
        m_drop_d = 1'b1;
      end
    end
  end

  // All control state, with an asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      str_cnt_q  <= '0;
      rdy_q      <= 1'b0;
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      drain_q    <= '0;
      i_q        <= 1'b0;
      i_c_q      <= '0;
      rx_clr_q   <= 1'b0;
      err_q      <= 1'b0;
      dl_valid_q <= '0;
      dl_pos_q   <= '0;
      m_valid_q  <= 1'b0;
      m_pos_q    <= '0;
      m_drop_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      str_cnt_q  <= str_cnt_d;
      rdy_q      <= 1'b1;
      state_q    <= state_d;
      pos_q      <= pos_d;
      drain_q    <= drain_d;
      i_q        <= i_d;
      i_c_q      <= i_c_d;
      rx_clr_q   <= rx_clr_d;
      err_q      <= err_d;
      dl_valid_q <= dl_valid_d;
      dl_pos_q   <= dl_pos_d;
      m_valid_q  <= m_valid_d;
      m_pos_q    <= m_pos_d;
      m_drop_q   <= m_drop_d;
    end
  end

  assign i       = i_q;
  assign i_c     = i_c_q;
  assign rx_clr  = rx_clr_q;
  assign err     = err_q;
  assign m_valid = m_valid_q;
  assign m_pos   = m_pos_q;
  assign m_drop  = m_drop_q;

endmodule
